// File: rtl/core_pkg.sv
// core_pkg: constants, fetch state encoding and instruction field positions shared across the core
package core_pkg;
  localparam logic [15:0] PC_STEP = 16'd2;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_e;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int REG1_HI = 11;
  localparam int REG1_LO = 8;
  localparam int REG2_HI = 7;
  localparam int REG2_LO = 4;
  localparam int RES_HI = 3;
  localparam int RES_LO = 0;
  localparam int OFF_HI = 7;
  localparam int OFF_LO = 0;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {ins, pc} with registered head
// Ports: clk, clr (async reset), push/din_*, pop, flush, cnt (0..2), head_ins/head_pc
module fetch_queue (
  input  logic        clk,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [15:0] din_ins,
  input  logic [15:0] din_pc,
  output logic [1:0]  cnt,
  output logic [15:0] head_ins,
  output logic [15:0] head_pc
);
  logic [15:0] tail_ins, tail_pc;
  logic load_head, shift, load_tail;
  // data lands in the head slot when the queue is empty or its only entry leaves this cycle
  assign load_head = push && (cnt == 2'd0 || (cnt == 2'd1 && pop));
  assign shift = pop && cnt == 2'd2;
  assign load_tail = push && !load_head;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      cnt <= 2'd0;
      head_ins <= 16'd0;
      head_pc <= 16'd0;
      tail_ins <= 16'd0;
      tail_pc <= 16'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (load_head) begin
        head_ins <= din_ins;
        head_pc <= din_pc;
      end else if (shift) begin
        head_ins <= tail_ins;
        head_pc <= tail_pc;
      end
      if (load_tail) begin
        tail_ins <= din_ins;
        tail_pc <= din_pc;
      end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing req/ack instruction fetches into a 2-entry queue, with redirect/flush
// Ports: clk, clr (async reset); redirect/redirect_addr from execute; imem_req/imem_addr/imem_ack/imem_rdata
// to memory; out_valid/out_ready/out_ins/out_pc to decode; align_err pulses on an odd redirect target
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_ins,
  output logic [15:0] out_pc,
  output logic        align_err
);
  fetch_state_e state;
  logic [15:0] req_addr, fetch_pc, tgt, nxt_pc;
  logic [1:0] cnt, cnt_next;
  logic push, pop, room;
  assign tgt = {redirect_addr[15:1], 1'b0};
  assign nxt_pc = req_addr + PC_STEP;
  assign push = state == REQ && imem_ack && !redirect;
  // a redirect flushes the queue, so a same-cycle pop consumes nothing
  assign pop = out_valid && out_ready && !redirect;
  assign cnt_next = redirect ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
  // only issue when the returning word is guaranteed a queue slot
  assign room = cnt_next < 2'd2;
  assign imem_req = state != IDLE;
  assign imem_addr = req_addr;
  assign out_valid = cnt != 2'd0;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      req_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      align_err <= 1'b0;
    end else begin
      align_err <= redirect && redirect_addr[0];
      if (redirect) begin
        fetch_pc <= tgt;
        // an unacked request must keep its address; its data is dropped when it returns
        if (state != IDLE && !imem_ack) state <= DROP;
        else begin
          state <= REQ;
          req_addr <= tgt;
        end
      end else if (state == IDLE || imem_ack) begin
        state <= room ? REQ : IDLE;
        req_addr <= state == REQ ? nxt_pc : fetch_pc;
        if (state == REQ) fetch_pc <= nxt_pc;
      end
    end
  fetch_queue u_queue (
    .clk(clk),
    .clr(clr),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .din_ins(imem_rdata),
    .din_pc(req_addr),
    .cnt(cnt),
    .head_ins(out_ins),
    .head_pc(out_pc)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a transaction-level model
module tb_fetch_unit;
  logic clk = 1'b0, clr = 1'b1, redirect = 1'b0, imem_ack = 1'b0, out_ready = 1'b0;
  logic [15:0] redirect_addr = 16'd0, imem_rdata = 16'd0;
  logic imem_req, out_valid, align_err;
  logic [15:0] imem_addr, out_ins, out_pc;
  int checks = 0, errors = 0;
  int lat_mode = 0;
  bit rnd_data = 0;
  int wl = -1;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk),
    .clr(clr),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ins(out_ins),
    .out_pc(out_pc),
    .align_err(align_err)
  );
  function automatic logic [15:0] pat(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction
  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  // memory: latency counted from the cycle a request is first seen; 0 acks in that same cycle
  always @(posedge clk) begin
    #2;
    if (clr || !imem_req) begin
      imem_ack = 1'b0;
      wl = -1;
    end else begin
      if (wl < 0) wl = lat_mode < 0 ? int'($urandom_range(3)) : lat_mode;
      imem_ack = wl == 0;
      imem_rdata = rnd_data ? 16'($urandom) : pat(imem_addr);
      wl = imem_ack ? -1 : wl - 1;
    end
  end
  // transaction-level model: outstanding fetch record, fetch pointer and a queue of {ins, pc}
  logic [31:0] q[$];
  bit m_out = 0, m_disc = 0, m_aerr = 0;
  logic [15:0] m_addr = 16'd0, m_pc = 16'd0;
  always @(negedge clk) begin
    if (clr) begin
      q.delete();
      m_out = 0;
      m_disc = 0;
      m_aerr = 0;
      m_pc = 16'h0000;
      chk1("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, 16'h0000);
      chk1("rst_valid", out_valid, 1'b0);
      chk("rst_ins", out_ins, 16'h0000);
      chk("rst_pc", out_pc, 16'h0000);
      chk1("rst_align_err", align_err, 1'b0);
    end else begin
      chk1("req", imem_req, m_out);
      if (m_out) chk("addr", imem_addr, m_addr);
      chk1("valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("ins", out_ins, q[0][31:16]);
        chk("pc", out_pc, q[0][15:0]);
      end
      chk1("align_err", align_err, m_aerr);
      m_aerr = redirect && redirect_addr[0];
      if (redirect) begin
        q.delete();
        m_pc = {redirect_addr[15:1], 1'b0};
        if (m_out && !imem_ack) m_disc = 1;
        else begin
          m_out = 1;
          m_disc = 0;
          m_addr = m_pc;
        end
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (m_out && imem_ack) begin
          if (!m_disc) begin
            q.push_back({imem_rdata, m_addr});
            m_pc = m_addr + 16'd2;
          end
          m_out = 0;
        end
        if (!m_out && q.size() < 2) begin
          m_out = 1;
          m_disc = 0;
          m_addr = m_pc;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #3;
  endtask
  task automatic do_reset();
    clr = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    clr = 1'b0;
  endtask
  initial begin
    lat_mode = 0;
    out_ready = 1'b1;
    do_reset();
    chk1("t1_rst_req", imem_req, 1'b0);
    chk("t1_rst_addr", imem_addr, 16'h0000);
    tick();
    chk1("t1_req", imem_req, 1'b1);
    chk("t1_addr0", imem_addr, 16'h0000);
    tick();
    chk("t1_addr2", imem_addr, 16'h0002);
    chk("t1_pc0", out_pc, 16'h0000);
    chk("t1_ins0", out_ins, 16'h5A5A);
    tick();
    chk("t1_addr4", imem_addr, 16'h0004);
    chk("t1_pc2", out_pc, 16'h0002);
    chk("t1_ins2", out_ins, 16'h585A);
    out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    chk1("t2_req_low", imem_req, 1'b0);
    chk1("t2_valid", out_valid, 1'b1);
    chk("t2_head0", out_pc, 16'h0000);
    tick();
    tick();
    chk1("t2_still_low", imem_req, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("t2_head2", out_pc, 16'h0002);
    chk1("t2_req_back", imem_req, 1'b1);
    chk("t2_addr4", imem_addr, 16'h0004);
    lat_mode = 3;
    do_reset();
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 16'h0004); i++) tick();
    chk("t3_reach4", imem_addr, 16'h0004);
    tick();
    redirect = 1'b1;
    redirect_addr = 16'h0100;
    tick();
    redirect = 1'b0;
    chk1("t3_hold_req", imem_req, 1'b1);
    chk("t3_hold_addr", imem_addr, 16'h0004);
    chk1("t3_flushed", out_valid, 1'b0);
    for (int i = 0; i < 20 && imem_addr == 16'h0004; i++) tick();
    chk("t3_target_addr", imem_addr, 16'h0100);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk1("t3_valid", out_valid, 1'b1);
    chk("t3_first_pc", out_pc, 16'h0100);
    chk("t3_first_ins", out_ins, 16'h5A5B);
    lat_mode = 0;
    do_reset();
    tick();
    tick();
    tick();
    redirect = 1'b1;
    redirect_addr = 16'h0203;
    tick();
    redirect = 1'b0;
    chk1("t4_align_err", align_err, 1'b1);
    chk1("t4_req", imem_req, 1'b1);
    chk("t4_addr", imem_addr, 16'h0202);
    chk1("t4_flushed", out_valid, 1'b0);
    tick();
    chk1("t4_pulse_end", align_err, 1'b0);
    chk("t4_pc", out_pc, 16'h0202);
    chk("t4_ins", out_ins, 16'h5858);
    redirect = 1'b1;
    redirect_addr = 16'hFFFE;
    tick();
    redirect = 1'b0;
    chk1("t5_no_err", align_err, 1'b0);
    chk("t5_addr", imem_addr, 16'hFFFE);
    tick();
    chk("t5_wrap_addr", imem_addr, 16'h0000);
    chk("t5_pc", out_pc, 16'hFFFE);
    chk("t5_ins", out_ins, 16'hA4A5);
    tick();
    chk("t5_wrap_pc", out_pc, 16'h0000);
    lat_mode = 3;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !(out_valid && imem_req); i++) tick();
    chk1("t6_busy", out_valid && imem_req, 1'b1);
    clr = 1'b1;
    #1;
    chk1("t6_req_async", imem_req, 1'b0);
    chk1("t6_valid_async", out_valid, 1'b0);
    tick();
    clr = 1'b0;
    tick();
    chk1("t6_restart_req", imem_req, 1'b1);
    chk("t6_restart_addr", imem_addr, 16'h0000);
    lat_mode = -1;
    rnd_data = 1;
    for (int i = 0; i < 4000; i++) begin
      out_ready = $urandom_range(9) < 7;
      redirect = $urandom_range(19) == 0;
      redirect_addr = $urandom_range(7) == 0 ? 16'hFFFE : 16'($urandom);
      clr = $urandom_range(499) == 0;
      tick();
    end
    redirect = 1'b0;
    clr = 1'b0;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
